// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state type, key code type, keypad geometry and the row priority helper
// used by the keypad scanner.
package keypad_pkg;
   localparam int NUM_COLS = 4;
   localparam int NUM_ROWS = 4;
   typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, COMMIT, EMIT} scan_state_t;
   typedef logic [3:0] key_code_t;
   // Index of the lowest set row; callers only pass non-zero vectors.
   function automatic logic [1:0] lowest_row(input logic [NUM_ROWS-1:0] v);
      return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : {v[3], v[3]};
   endfunction
endpackage

// File: rtl/keypad_scan_ctrl_row_sampler.sv
// row_sampler: 2-FF synchronizer for the raw row lines plus per-window reference capture
// and stability compare.
module row_sampler
   import keypad_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_ROWS-1:0] row_in,
   input  logic                start,
   input  logic                sample_en,
   output logic [NUM_ROWS-1:0] row_sync,
   output logic [NUM_ROWS-1:0] row_ref,
   output logic                stable
);
   logic [NUM_ROWS-1:0] meta_q, sync_q, ref_q;
   logic                stable_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q   <= '0;
         sync_q   <= '0;
         ref_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         meta_q <= row_in;
         sync_q <= meta_q;
         if (start) begin
            ref_q    <= sync_q;
            stable_q <= 1'b1;
         end else if (sample_en && sync_q != ref_q) begin
            stable_q <= 1'b0;
         end
      end
   end
   assign row_sync = sync_q;
   assign row_ref  = ref_q;
   assign stable   = stable_q;
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 keypad column scanner with per-column debounce, held-key map and a
// key-event FIFO on valid/ready. Define KEYPAD_RELEASE_EVENT_EN to also emit release events.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int DWELL_CYCLES  = 8,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_ROWS-1:0]          row_in,
   output logic [NUM_COLS-1:0]          col_out,
   output logic                         key_valid,
   output key_code_t                    key_code,
   input  logic                         key_ready,
`ifdef KEYPAD_RELEASE_EVENT_EN
   output logic                         key_release,
`endif
   output logic [NUM_COLS*NUM_ROWS-1:0] pressed_map,
   output logic                         overflow
);
   localparam int CW = $clog2((SETTLE_CYCLES > DWELL_CYCLES ? SETTLE_CYCLES : DWELL_CYCLES) + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
`ifdef KEYPAD_RELEASE_EVENT_EN
   localparam int EW = 5;
`else
   localparam int EW = 4;
`endif

   scan_state_t                  state_q, state_d;
   logic [1:0]                   col_q, col_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic [NUM_ROWS-1:0]          pend_q, pend_d;
`ifdef KEYPAD_RELEASE_EVENT_EN
   logic [NUM_ROWS-1:0]          rel_q, rel_d;
`endif
   logic [NUM_COLS*NUM_ROWS-1:0] map_q, map_d;
   logic [NUM_ROWS-1:0]          col_map, row_ref, unused_row_sync;
   logic                         stable, start, sample_en, settle_done, dwell_done, done;
   logic                         push, push_ok, pop, full;
   logic [EW-1:0]                push_data, head;
   logic [EW-1:0]                mem_q [FIFO_DEPTH];
   logic [AW-1:0]                rd_q, wr_q;
   logic [AW:0]                  count_q;
   logic                         ovf_q;

   row_sampler u_sampler (
      .clk       (clk),
      .rst       (rst),
      .row_in    (row_in),
      .start     (start),
      .sample_en (sample_en),
      .row_sync  (unused_row_sync),
      .row_ref   (row_ref),
      .stable    (stable)
   );

   assign settle_done = cnt_q == CW'(SETTLE_CYCLES - 1);
   assign dwell_done  = cnt_q == CW'(DWELL_CYCLES - 1);
   assign start       = state_q == SAMPLE && cnt_q == '0;
   assign sample_en   = state_q == SAMPLE && cnt_q != '0;
   assign col_map     = map_q[{col_q, 2'b00} +: NUM_ROWS];
   assign col_out     = (state_q == IDLE) ? '0 : 4'b0001 << col_q;

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      map_d     = map_q;
      push      = 1'b0;
      push_data = '0;
`ifdef KEYPAD_RELEASE_EVENT_EN
      rel_d     = rel_q;
`endif
      case (state_q)
         IDLE: begin
            state_d = SETTLE;
            col_d   = '0;
            cnt_d   = '0;
         end
         SETTLE: begin
            state_d = settle_done ? SAMPLE : SETTLE;
            cnt_d   = settle_done ? '0 : cnt_q + 1'b1;
         end
         SAMPLE: begin
            state_d = dwell_done ? COMMIT : SAMPLE;
            cnt_d   = dwell_done ? '0 : cnt_q + 1'b1;
         end
         COMMIT: begin
            state_d = EMIT;
            pend_d  = stable ? row_ref & ~col_map : '0;
`ifdef KEYPAD_RELEASE_EVENT_EN
            rel_d   = stable ? ~row_ref & col_map : '0;
`endif
            if (stable) map_d[{col_q, 2'b00} +: NUM_ROWS] = row_ref;
         end
         EMIT: begin
            push = 1'b1;
`ifdef KEYPAD_RELEASE_EVENT_EN
            // Presses drain before releases, each lowest row first.
            push_data = (pend_q != '0) ? {1'b0, col_q, lowest_row(pend_q)}
                                       : {1'b1, col_q, lowest_row(rel_q)};
            rel_d     = (pend_q != '0) ? rel_q : rel_q & (rel_q - 1'b1);
`else
            push_data = {col_q, lowest_row(pend_q)};
`endif
            pend_d    = pend_q & (pend_q - 1'b1);
         end
         default: state_d = IDLE;
      endcase
`ifdef KEYPAD_RELEASE_EVENT_EN
      done = (pend_d | rel_d) == '0;
`else
      done = pend_d == '0;
`endif
      if ((state_q == COMMIT || state_q == EMIT) && done) begin
         state_d = SETTLE;
         col_d   = col_q + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= '0;
`ifdef KEYPAD_RELEASE_EVENT_EN
         rel_q   <= '0;
`endif
         map_q   <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
`ifdef KEYPAD_RELEASE_EVENT_EN
         rel_q   <= rel_d;
`endif
         map_q   <= map_d;
      end
   end

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign full      = count_q == (AW+1)'(FIFO_DEPTH);
   assign key_valid = count_q != '0;
   assign pop       = key_valid & key_ready;
   assign push_ok   = push & (~full | pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_q] <= push_data;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
         if (push & full & ~pop) ovf_q <= 1'b1;
      end
   end

   assign head        = mem_q[rd_q];
   assign key_code    = head[3:0];
`ifdef KEYPAD_RELEASE_EVENT_EN
   assign key_release = head[4];
`endif
   assign pressed_map = map_q;
   assign overflow    = ovf_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: emulates a 4x4 keypad on the scanner pins and checks every cycle
// against a visit-schedule model of scan timing, debounce windows, event list and FIFO.
module tb_keypad_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  row_in = '0;
   logic [3:0]  col_out;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        key_ready = 1'b0;
   logic [15:0] pressed_map;
   logic        overflow;

   int checks = 0, errors = 0;

   keypad_scan_ctrl #(.SETTLE_CYCLES(2), .DWELL_CYCLES(8), .FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .row_in      (row_in),
      .col_out     (col_out),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_ready   (key_ready),
      .pressed_map (pressed_map),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   // Model: a column visit is 2 settle + 8 window + 1 commit + one cycle per new press.
   bit          m_idle = 1;
   int          m_col = 0, m_off = 0, m_n = 0;
   logic [3:0]  m_win [8];
   logic [3:0]  m_codes [$];
   logic [15:0] m_map = '0;
   logic [3:0]  m_q [$];
   bit          m_ovf = 0;

   logic [15:0] held = '0;
   logic [3:0]  noise = '0;
   bit          rst_req = 1, bounce = 0;
   int          ready_mode = 1;
   logic [3:0]  seen [$];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_idle = 1;
      m_col  = 0;
      m_off  = 0;
      m_map  = '0;
      m_ovf  = 0;
      m_q.delete();
   endtask

   task automatic drive();
      logic [3:0] r;
      rst = rst_req;
      r = m_idle ? 4'h0 : held[m_col*4 +: 4] ^ noise;
      if (bounce && !m_idle && m_col == 3 && m_off >= 3 && m_off <= 5) begin
         r ^= 4'b0010;
         if (m_off == 5) bounce = 0;
      end
      row_in = r;
      case (ready_mode)
         0: key_ready = 1'b0;
         1: key_ready = 1'b1;
         2: key_ready = 1'($urandom_range(0, 1));
         default: key_ready = !m_idle && m_col == 2 && m_off >= 11;
      endcase
   endtask

   task automatic step();
      bit pop, full, stable;
      if (rst) begin
         model_reset();
         return;
      end
      if (m_idle) begin
         m_idle = 0;
         m_col  = 0;
         m_off  = 0;
         m_n    = 0;
         return;
      end
      pop  = m_q.size() != 0 && key_ready;
      full = m_q.size() == 4;
      if (pop) void'(m_q.pop_front());
      if (m_off < 8) m_win[m_off] = row_in;
      if (m_off == 10) begin
         stable = 1;
         for (int i = 1; i < 8; i++) if (m_win[i] != m_win[0]) stable = 0;
         m_codes.delete();
         if (stable) begin
            for (int r = 0; r < 4; r++)
               if (m_win[0][r] && !m_map[m_col*4 + r]) m_codes.push_back(4'(m_col*4 + r));
            m_map[m_col*4 +: 4] = m_win[0];
         end
         m_n = m_codes.size();
      end
      if (m_off >= 11) begin
         if (!full || pop) m_q.push_back(m_codes[m_off-11]);
         else m_ovf = 1;
      end
      if (m_off == 10 + m_n) begin
         m_col = (m_col + 1) % 4;
         m_off = 0;
      end else begin
         m_off++;
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      chk("col_out", col_out, m_idle ? 0 : 1 << m_col);
      chk("key_valid", key_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("key_code", key_code, m_q[0]);
      chk("pressed_map", pressed_map, m_map);
      chk("overflow", overflow, m_ovf);
      drive();
      if (key_valid && key_ready) seen.push_back(key_code);
      step();
   endtask

   task automatic run(int n);
      repeat (n) cycle();
   endtask

   task automatic wait_for(int c, int o);
      int n = 0;
      while (!(!m_idle && m_col == c && m_off == o) && n < 300) begin
         cycle();
         n++;
      end
      checks++;
      assert (n < 300) else begin
         errors++;
         $error("FAIL wait_for col=%0d off=%0d observed=timeout expected=reached", c, o);
      end
   endtask

   task automatic expect_seen(string tag, int n, logic [31:0] codes);
      chk({tag, "_count"}, seen.size(), n);
      for (int i = 0; i < n; i++)
         chk($sformatf("%s[%0d]", tag, i), (i < seen.size()) ? seen[i] : 4'hx, codes[i*4 +: 4]);
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (3) cycle();
      chk("rst_col_out", col_out, 0);
      chk("rst_key_valid", key_valid, 0);
      chk("rst_key_code", key_code, 0);
      chk("rst_map", pressed_map, 0);
      chk("rst_overflow", overflow, 0);
      rst_req = 0;
      run(100);
      chk("no_key_events", seen.size(), 0);

      held[6] = 1'b1;
      run(5 * 44);
      expect_seen("press6", 1, 32'h6);
      chk("press6_map", pressed_map, 16'h0040);

      held = 16'h1000;
      seen.delete();
      run(100);
      expect_seen("press12", 1, 32'hC);
      seen.delete();
      bounce = 1;
      run(60);
      chk("bounce_events", seen.size(), 0);
      chk("bounce_map", pressed_map, 16'h1000);
      held[13] = 1'b1;
      run(100);
      expect_seen("press13", 1, 32'hD);
      chk("press13_map", pressed_map, 16'h3000);

      held = '0;
      run(100);
      seen.delete();
      ready_mode = 0;
      wait_for(3, 0);
      held = 16'h000B;
      run(30);
      chk("bp_valid", key_valid, 1);
      chk("bp_head", key_code, 0);
      run(10);
      chk("bp_head_hold", key_code, 0);
      ready_mode = 1;
      run(5);
      expect_seen("bp_drain", 3, 32'h310);

      held = '0;
      run(100);
      seen.delete();
      ready_mode = 0;
      wait_for(0, 0);
      held = 16'h01F0;
      run(60);
      chk("ovf_flag", overflow, 1);
      chk("ovf_valid", key_valid, 1);
      chk("ovf_head", key_code, 4);
      ready_mode = 1;
      run(10);
      expect_seen("ovf_drain", 4, 32'h7654);

      held = '0;
      run(100);
      seen.delete();
      ready_mode = 0;
      wait_for(3, 0);
      held = 16'h000F;
      wait_for(0, 12);
      rst_req = 1;
      cycle();
      cycle();
      chk("mid_rst_col_out", col_out, 0);
      chk("mid_rst_valid", key_valid, 0);
      chk("mid_rst_code", key_code, 0);
      chk("mid_rst_map", pressed_map, 0);
      chk("mid_rst_overflow", overflow, 0);
      rst_req = 0;
      ready_mode = 1;
      seen.delete();
      run(100);
      expect_seen("redetect", 4, 32'h3210);

      seen.delete();
      ready_mode = 0;
      wait_for(0, 0);
      held = 16'h02FF;
      ready_mode = 3;
      run(60);
      chk("full_pop_push_ovf", overflow, 0);
      ready_mode = 1;
      run(10);
      expect_seen("full_pop_push", 5, 32'h97654);

      ready_mode = 2;
      for (int i = 0; i < 40; i++) begin
         int len;
         held ^= 16'(1) << $urandom_range(0, 15);
         len = $urandom_range(10, 60);
         for (int j = 0; j < len; j++) begin
            noise = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'h0;
            cycle();
         end
      end
      noise = '0;
      run(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
